// File: rtl/uart_deserializer_if.sv
// FIFO write-side bundle between the UART receive deserializer (master)
// and the RX FIFO (slave).
interface uart_deserializer_if;
   logic       fifo_full_i;
   logic       fifo_wr_en_o;
   logic [7:0] fifo_wr_data_o;

   modport master (input fifo_full_i, output fifo_wr_en_o, output fifo_wr_data_o);
   modport slave  (output fifo_full_i, input fifo_wr_en_o, input fifo_wr_data_o);
endinterface

// File: rtl/uart_deserializer.sv
// UART 8N1 receive deserializer: synchronises rx_i, finds start bits on the
// oversampled tick, samples mid-bit (LSB first) and strobes good bytes into the RX FIFO.
module uart_deserializer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_en_i,
   input  logic                rx_i,
   uart_deserializer_if.master fifo,
   output logic                frame_err_o,
   output logic                overrun_err_o,
   output logic                busy_o
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t          r_state;
   logic [TW-1:0]   r_tick_cnt;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shift_reg;
   logic            r_rx_meta;
   logic            r_rx_s;
   logic            r_wr_en;
   logic [7:0]      r_wr_data;
   logic            r_frame_err;
   logic            r_overrun_err;
   logic            r_busy;

   // Both synchroniser flops reset to the idle-high line level so reset
   // release never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         r_rx_meta <= rx_i;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_tick_cnt    <= '0;
         r_bit_cnt     <= '0;
         r_shift_reg   <= '0;
         r_wr_en       <= 1'b0;
         r_wr_data     <= '0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_wr_en       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
         r_busy        <= (r_state != S_IDLE);

         if (sample_en_i) begin
            unique case (r_state)
               S_IDLE: begin
                  if (!r_rx_s) begin
                     r_state    <= S_START;
                     r_tick_cnt <= '0;
                  end
               end

               S_START: begin
                  if (r_tick_cnt == TICK_MID) begin
                     if (r_rx_s) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_state    <= S_DATA;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end

               S_DATA: begin
                  if (r_tick_cnt == TICK_END) begin
                     r_shift_reg <= {r_rx_s, r_shift_reg[7:1]};
                     r_tick_cnt  <= '0;
                     r_bit_cnt   <= r_bit_cnt + 1'b1;
                     if (r_bit_cnt == 3'd7) r_state <= S_STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end

               // Leaving at mid stop bit leaves half a bit of slack for a
               // back-to-back start edge.
               S_STOP: begin
                  if (r_tick_cnt == TICK_END) begin
                     r_tick_cnt <= '0;
                     if (!r_rx_s) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_WAIT_IDLE;
                     end else if (fifo.fifo_full_i) begin
                        r_overrun_err <= 1'b1;
                        r_state       <= S_IDLE;
                     end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= r_shift_reg;
                        r_state   <= S_IDLE;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end

               // A held-low line (break) must not decode as repeated 0x00 frames.
               S_WAIT_IDLE: begin
                  if (r_rx_s) r_state <= S_IDLE;
               end

               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign fifo.fifo_wr_en_o   = r_wr_en;
   assign fifo.fifo_wr_data_o = r_wr_data;
   assign frame_err_o         = r_frame_err;
   assign overrun_err_o       = r_overrun_err;
   assign busy_o              = r_busy;

endmodule

// File: tb/tb_uart_deserializer.sv
// Directed bench for uart_deserializer: table of single frames plus hand-written
// sequences for strobe timing, glitch, break, back-to-back, overrun and reset.
module tb_uart_deserializer;

   localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clk

   logic        clk;
   logic        rst_n;
   logic        sample_en_i;
   logic        rx_i;
   logic        frame_err_o;
   logic        overrun_err_o;
   logic        busy_o;
   logic [31:0] cyc = '0;

   uart_deserializer_if u_if ();

   uart_deserializer #(.OVERSAMPLE(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_en_i   (sample_en_i),
      .rx_i          (rx_i),
      .fifo          (u_if),
      .frame_err_o   (frame_err_o),
      .overrun_err_o (overrun_err_o),
      .busy_o        (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tick lands on every posedge where cyc (pre-edge) is 3 mod 4.
   always @(posedge clk) cyc <= cyc + 1;
   assign sample_en_i = (cyc[1:0] == 2'd3);

   int          checks   = 0;
   int          failures = 0;
   int          wr_cnt   = 0;
   int          ferr_cnt = 0;
   int          ovr_cnt  = 0;
   int          wide_cnt = 0;
   logic        prev_wr  = 1'b0;
   logic        prev_fe  = 1'b0;
   logic        prev_ov  = 1'b0;
   logic [7:0]  rx_q[$];

   always @(negedge clk) begin
      if (u_if.fifo_wr_en_o) begin
         wr_cnt++;
         rx_q.push_back(u_if.fifo_wr_data_o);
      end
      if (frame_err_o)   ferr_cnt++;
      if (overrun_err_o) ovr_cnt++;
      if ((u_if.fifo_wr_en_o && prev_wr) || (frame_err_o && prev_fe) ||
          (overrun_err_o && prev_ov))
         wide_cnt++;
      prev_wr = u_if.fifo_wr_en_o;
      prev_fe = frame_err_o;
      prev_ov = overrun_err_o;
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Call at a negedge; returns at a negedge whose following posedge is a tick.
   task automatic align();
      while (cyc[1:0] != 2'd3) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      align();
      rx_i = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         rx_i = data[b];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx_i = stop_bit;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      logic       full;
      int         exp_wr;
      logic [7:0] exp_data;
      int         exp_ferr;
      int         exp_ovr;
   } vec_t;

   vec_t vecs[6];

   int         base_wr, base_fe, base_ov, base_q, elapsed;
   logic       found;

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0, 0};
      vecs[1] = '{8'h3C, 1'b1, 1'b0, 1, 8'h3C, 0, 0};
      vecs[2] = '{8'h81, 1'b1, 1'b1, 0, 8'h00, 0, 1};
      vecs[3] = '{8'h5A, 1'b0, 1'b0, 0, 8'h00, 1, 0};
      vecs[4] = '{8'h01, 1'b1, 1'b0, 1, 8'h01, 0, 0};
      vecs[5] = '{8'h80, 1'b1, 1'b0, 1, 8'h80, 0, 0};

      rst_n            = 1'b0;
      rx_i             = 1'b1;
      u_if.fifo_full_i = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_wr_en",   u_if.fifo_wr_en_o,   0);
      check("reset_wr_data", u_if.fifo_wr_data_o, 8'h00);
      check("reset_ferr",    frame_err_o,         0);
      check("reset_ovr",     overrun_err_o,       0);
      check("reset_busy",    busy_o,              0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);

      // Single-frame vectors
      foreach (vecs[i]) begin
         base_wr = wr_cnt; base_fe = ferr_cnt; base_ov = ovr_cnt;
         u_if.fifo_full_i = vecs[i].full;
         send_frame(vecs[i].data, vecs[i].stop_bit);
         rx_i = 1'b1;
         repeat (160) @(negedge clk);
         u_if.fifo_full_i = 1'b0;
         check($sformatf("vec%0d_wr", i),   wr_cnt - base_wr,   vecs[i].exp_wr);
         check($sformatf("vec%0d_ferr", i), ferr_cnt - base_fe, vecs[i].exp_ferr);
         check($sformatf("vec%0d_ovr", i),  ovr_cnt - base_ov,  vecs[i].exp_ovr);
         if (vecs[i].exp_wr == 1) begin
            check($sformatf("vec%0d_data", i), rx_q[rx_q.size()-1], vecs[i].exp_data);
            check($sformatf("vec%0d_hold", i), u_if.fifo_wr_data_o, vecs[i].exp_data);
         end
         check($sformatf("vec%0d_idle", i), busy_o, 0);
      end

      // Strobe latency: tick n is the 2nd tick after rx_i falls, stop sample at n+152,
      // so the strobe is seen 4 + 152*4 + 1 = 613 posedges after the fall.
      base_wr = wr_cnt; base_fe = ferr_cnt; base_ov = ovr_cnt;
      align();
      found   = 1'b0;
      elapsed = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            for (int k = 0; k < 700; k++) begin
               if (!found) begin
                  @(posedge clk);
                  elapsed++;
                  @(negedge clk);
                  if (u_if.fifo_wr_en_o) found = 1'b1;
               end
            end
         end
      join
      repeat (100) @(negedge clk);
      check("lat_found",  found,   1);
      check("lat_cycles", elapsed, 613);
      check("lat_wr",     wr_cnt - base_wr, 1);
      check("lat_data",   u_if.fifo_wr_data_o, 8'hA5);
      check("lat_noerr",  (ferr_cnt - base_fe) + (ovr_cnt - base_ov), 0);

      // Glitch: low for 4 ticks; start check at tick n+8 returns to IDLE
      base_wr = wr_cnt;
      align();
      rx_i = 1'b0;
      repeat (16) @(negedge clk);
      rx_i = 1'b1;
      check("glitch_busy_hi", busy_o, 1);
      repeat (21) @(negedge clk);
      check("glitch_busy_last", busy_o, 1);
      @(negedge clk);
      check("glitch_busy_drop", busy_o, 0);
      repeat (200) @(negedge clk);
      check("glitch_no_wr", wr_cnt - base_wr, 0);

      // Framing error then break held for 20 bit times
      base_wr = wr_cnt; base_fe = ferr_cnt;
      send_frame(8'h00, 1'b0);
      repeat (20 * BIT_CLKS) @(negedge clk);
      check("break_ferr",  ferr_cnt - base_fe, 1);
      check("break_no_wr", wr_cnt - base_wr,   0);
      check("break_busy",  busy_o,             1);
      rx_i = 1'b1;
      repeat (128) @(negedge clk);
      check("break_idle",  busy_o, 0);
      send_frame(8'h3C, 1'b1);
      repeat (160) @(negedge clk);
      check("after_break_wr",   wr_cnt - base_wr,    1);
      check("after_break_data", rx_q[rx_q.size()-1], 8'h3C);
      check("after_break_ferr", ferr_cnt - base_fe,  1);

      // Full only mid-frame, released before the stop sample
      base_wr = wr_cnt; base_ov = ovr_cnt;
      align();
      fork
         send_frame(8'h96, 1'b1);
         begin
            repeat (300) @(negedge clk);
            u_if.fifo_full_i = 1'b1;
            repeat (200) @(negedge clk);
            u_if.fifo_full_i = 1'b0;
         end
      join
      repeat (160) @(negedge clk);
      check("midfull_wr",   wr_cnt - base_wr,    1);
      check("midfull_data", rx_q[rx_q.size()-1], 8'h96);
      check("midfull_ovr",  ovr_cnt - base_ov,   0);

      // Back-to-back frames, zero idle gap
      base_wr = wr_cnt; base_fe = ferr_cnt; base_ov = ovr_cnt; base_q = rx_q.size();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      repeat (200) @(negedge clk);
      check("b2b_wr",    wr_cnt - base_wr, 3);
      check("b2b_err",   (ferr_cnt - base_fe) + (ovr_cnt - base_ov), 0);
      if (rx_q.size() >= base_q + 3) begin
         check("b2b_d0", rx_q[base_q],     8'h00);
         check("b2b_d1", rx_q[base_q + 1], 8'hFF);
         check("b2b_d2", rx_q[base_q + 2], 8'h55);
      end

      // Reset during data bit 3; held until the partial frame has passed
      base_wr = wr_cnt;
      align();
      fork
         send_frame(8'h7E, 1'b1);
         begin
            repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
            check("rst_mid_busy_before", busy_o, 1);
            rst_n = 1'b0;
            #1;
            check("rst_mid_busy",    busy_o,              0);
            check("rst_mid_wr_en",   u_if.fifo_wr_en_o,   0);
            check("rst_mid_wr_data", u_if.fifo_wr_data_o, 8'h00);
            check("rst_mid_ferr",    frame_err_o,         0);
            check("rst_mid_ovr",     overrun_err_o,       0);
         end
      join
      @(negedge clk);
      rst_n = 1'b1;
      repeat (64) @(negedge clk);
      check("rst_mid_no_wr", wr_cnt - base_wr, 0);
      send_frame(8'h7E, 1'b1);
      repeat (160) @(negedge clk);
      check("rst_after_wr",   wr_cnt - base_wr,    1);
      check("rst_after_data", rx_q[rx_q.size()-1], 8'h7E);

      check("pulse_width_one", wide_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
